// File: rtl/dbg_stream_pkg.sv
// dbg_stream_pkg: shared types and helpers for the debug bus streamer.
//   state_e      - streamer FSM states
//   phase_e      - which byte class (header/data/checksum) is in flight
//   SYNC_BYTE_DEFAULT - default header sync value
//   calc_nbytes  - bytes needed to hold a bus of the given bit width
// Optional checksum state/phase are present only when DBG_STREAM_CHECKSUM_EN
// is defined.
package dbg_stream_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HDR,
    SEND,
    WAIT_BUSY,
    WAIT_IDLE,
`ifdef DBG_STREAM_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_HDR,
    PH_DATA
`ifdef DBG_STREAM_CHECKSUM_EN
    , PH_CSUM
`endif
  } phase_e;

  function automatic int unsigned calc_nbytes(input int unsigned bus_w);
    return (bus_w + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/dbg_byte_sel.sv
// dbg_byte_sel: combinational byte picker over a zero-padded snapshot.
//   snap     in  NBYTES*8  padded snapshot
//   idx      in  IDX_W     logical byte index
//   byte_out out 8         selected byte (0 when idx is out of range)
// MSB_FIRST=1 maps index 0 to the top byte, otherwise to snap[7:0].
module dbg_byte_sel #(
  parameter int unsigned NBYTES    = 3,
  parameter int unsigned IDX_W     = 16,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic [NBYTES*8-1:0] snap,
  input  logic [IDX_W-1:0]    idx,
  output logic [7:0]          byte_out
);

  int unsigned pos;

  always_comb begin
    pos = 32'(idx);
    if (MSB_FIRST) begin
      // Underflows to a huge value when idx is out of range; caught below.
      pos = NBYTES - 32'd1 - pos;
    end
    byte_out = '0;
    if (pos < NBYTES) begin
      byte_out = snap[pos*8 +: 8];
    end
  end

endmodule

// File: rtl/dbg_bus_streamer.sv
// dbg_bus_streamer: snapshots a wide debug bus on request and streams a byte
// window of it into a UART transmitter, optionally framed by a sync byte and
// a 16-bit length (high byte first).
//   clock      in   system clock
//   reset      in   asynchronous active-low reset
//   send       in   one-cycle start request (ignored while busy)
//   data_in    in   debug bus, captured on an accepted send
//   win_start  in   first byte index of the window
//   win_len    in   window length in bytes, 0 = to end of bus
//   tx_busy    in   UART transmitter busy
//   wr_uart    out  one-cycle UART write strobe
//   w_data     out  byte to transmit, held between strobes
//   busy       out  stream in progress
//   dataSent   out  one-cycle pulse after the final byte completes
//   err        out  one-cycle pulse on a rejected request (win_start >= NBYTES)
// Define DBG_STREAM_CHECKSUM_EN to append an XOR checksum byte over all
// header and data bytes of the frame.
module dbg_bus_streamer
  import dbg_stream_pkg::*;
#(
  parameter int unsigned BUS_W     = 1729,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          HDR_EN    = 1'b1,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int unsigned IDX_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             send,
  input  logic [BUS_W-1:0] data_in,
  input  logic [IDX_W-1:0] win_start,
  input  logic [IDX_W-1:0] win_len,
  input  logic             tx_busy,
  output logic             wr_uart,
  output logic [7:0]       w_data,
  output logic             busy,
  output logic             dataSent,
  output logic             err
);

  localparam int unsigned NBYTES = calc_nbytes(BUS_W);
  localparam int unsigned PAD_W  = NBYTES * 8;

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [PAD_W-1:0]  snap_q, snap_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  win_len_q, win_len_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       rem_q, rem_d;
  logic [1:0]        hdr_cnt_q, hdr_cnt_d;
  logic              wr_uart_q, wr_uart_d;
  logic [7:0]        w_data_q, w_data_d;
  logic              busy_q, busy_d;
  logic              data_sent_q, data_sent_d;
  logic              err_q, err_d;
`ifdef DBG_STREAM_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic [7:0]        data_byte;
  logic [7:0]        hdr_byte;
  int unsigned       avail;
  int unsigned       req_len;
  int unsigned       eff_len;

  dbg_byte_sel #(
    .NBYTES    (NBYTES),
    .IDX_W     (IDX_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_byte_sel (
    .snap     (snap_q),
    .idx      (idx_q),
    .byte_out (data_byte)
  );

  always_comb begin
    unique case (hdr_cnt_q)
      2'd0:    hdr_byte = SYNC_BYTE;
      2'd1:    hdr_byte = len_q[15:8];
      default: hdr_byte = len_q[7:0];
    endcase
  end

  // idx_q still holds win_start while in LOAD; oversized windows are clipped.
  always_comb begin
    avail   = NBYTES - 32'(idx_q);
    req_len = 32'(win_len_q);
    eff_len = ((req_len == 32'd0) || (req_len > avail)) ? avail : req_len;
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    snap_d      = snap_q;
    idx_d       = idx_q;
    win_len_d   = win_len_q;
    len_d       = len_q;
    rem_d       = rem_q;
    hdr_cnt_d   = hdr_cnt_q;
    wr_uart_d   = 1'b0;
    w_data_d    = w_data_q;
    busy_d      = busy_q;
    data_sent_d = 1'b0;
    err_d       = 1'b0;
`ifdef DBG_STREAM_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (send) begin
          if (32'(win_start) >= NBYTES) begin
            err_d = 1'b1;
          end else begin
            snap_d    = PAD_W'(data_in);
            idx_d     = win_start;
            win_len_d = win_len;
            busy_d    = 1'b1;
            state_d   = LOAD;
          end
        end
      end

      LOAD: begin
        len_d     = 16'(eff_len);
        rem_d     = 16'(eff_len);
        hdr_cnt_d = '0;
`ifdef DBG_STREAM_CHECKSUM_EN
        csum_d    = '0;
`endif
        if (HDR_EN) begin
          phase_d = PH_HDR;
          state_d = HDR;
        end else begin
          phase_d = PH_DATA;
          state_d = SEND;
        end
      end

      HDR: begin
        if (!tx_busy) begin
          wr_uart_d = 1'b1;
          w_data_d  = hdr_byte;
`ifdef DBG_STREAM_CHECKSUM_EN
          csum_d    = csum_q ^ hdr_byte;
`endif
          state_d   = WAIT_BUSY;
        end
      end

      SEND: begin
        if (!tx_busy) begin
          wr_uart_d = 1'b1;
          w_data_d  = data_byte;
`ifdef DBG_STREAM_CHECKSUM_EN
          csum_d    = csum_q ^ data_byte;
`endif
          state_d   = WAIT_BUSY;
        end
      end

`ifdef DBG_STREAM_CHECKSUM_EN
      CSUM: begin
        if (!tx_busy) begin
          wr_uart_d = 1'b1;
          w_data_d  = csum_q;
          phase_d   = PH_CSUM;
          state_d   = WAIT_BUSY;
        end
      end
`endif

      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        if (!tx_busy) begin
          unique case (phase_q)
            PH_HDR: begin
              if (hdr_cnt_q == 2'd2) begin
                phase_d = PH_DATA;
                state_d = SEND;
              end else begin
                hdr_cnt_d = hdr_cnt_q + 2'd1;
                state_d   = HDR;
              end
            end
            PH_DATA: begin
              if (rem_q == 16'd1) begin
`ifdef DBG_STREAM_CHECKSUM_EN
                state_d = CSUM;
`else
                state_d = DONE;
`endif
              end else begin
                idx_d   = idx_q + IDX_W'(1);
                rem_d   = rem_q - 16'd1;
                state_d = SEND;
              end
            end
            default: begin
              state_d = DONE;
            end
          endcase
        end
      end

      DONE: begin
        data_sent_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      phase_q     <= PH_HDR;
      snap_q      <= '0;
      idx_q       <= '0;
      win_len_q   <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      hdr_cnt_q   <= '0;
      wr_uart_q   <= 1'b0;
      w_data_q    <= '0;
      busy_q      <= 1'b0;
      data_sent_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef DBG_STREAM_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      snap_q      <= snap_d;
      idx_q       <= idx_d;
      win_len_q   <= win_len_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      hdr_cnt_q   <= hdr_cnt_d;
      wr_uart_q   <= wr_uart_d;
      w_data_q    <= w_data_d;
      busy_q      <= busy_d;
      data_sent_q <= data_sent_d;
      err_q       <= err_d;
`ifdef DBG_STREAM_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign wr_uart  = wr_uart_q;
  assign w_data   = w_data_q;
  assign busy     = busy_q;
  assign dataSent = data_sent_q;
  assign err      = err_q;

endmodule

// File: tb/tb_dbg_bus_streamer.sv
// Bench for dbg_bus_streamer: three instances with different configurations
//   u0: BUS_W=24, MSB_FIRST=1, HDR_EN=1
//   u1: BUS_W=24, MSB_FIRST=0, HDR_EN=1
//   u2: BUS_W=20, MSB_FIRST=1, HDR_EN=0
// each driven by a UART model that raises tx_busy the cycle after a strobe.
module tb_dbg_bus_streamer;

  logic        clock = 1'b0;
  logic        reset;
  logic        send_s    [3];
  logic [23:0] din_s     [3];
  logic [15:0] ws_s      [3];
  logic [15:0] wl_s      [3];
  logic        tx_busy_s [3];
  logic        wr_s      [3];
  logic [7:0]  wd_s      [3];
  logic        busy_s    [3];
  logic        ds_s      [3];
  logic        err_s     [3];
  int          hold_len  [3];
  int          bcnt      [3];

  int total = 0;
  int bad   = 0;

  int nb_of  [3] = '{3, 3, 3};
  int bw_of  [3] = '{24, 24, 20};
  int msb_of [3] = '{1, 0, 1};
  int hdr_of [3] = '{1, 1, 0};

  always #5 clock = ~clock;

  dbg_bus_streamer #(.BUS_W(24), .MSB_FIRST(1'b1), .HDR_EN(1'b1), .SYNC_BYTE(8'hA5), .IDX_W(16)) u0 (
    .clock(clock), .reset(reset), .send(send_s[0]), .data_in(din_s[0]),
    .win_start(ws_s[0]), .win_len(wl_s[0]), .tx_busy(tx_busy_s[0]),
    .wr_uart(wr_s[0]), .w_data(wd_s[0]), .busy(busy_s[0]), .dataSent(ds_s[0]), .err(err_s[0]));

  dbg_bus_streamer #(.BUS_W(24), .MSB_FIRST(1'b0), .HDR_EN(1'b1), .SYNC_BYTE(8'hA5), .IDX_W(16)) u1 (
    .clock(clock), .reset(reset), .send(send_s[1]), .data_in(din_s[1]),
    .win_start(ws_s[1]), .win_len(wl_s[1]), .tx_busy(tx_busy_s[1]),
    .wr_uart(wr_s[1]), .w_data(wd_s[1]), .busy(busy_s[1]), .dataSent(ds_s[1]), .err(err_s[1]));

  dbg_bus_streamer #(.BUS_W(20), .MSB_FIRST(1'b1), .HDR_EN(1'b0), .SYNC_BYTE(8'hA5), .IDX_W(16)) u2 (
    .clock(clock), .reset(reset), .send(send_s[2]), .data_in(din_s[2][19:0]),
    .win_start(ws_s[2]), .win_len(wl_s[2]), .tx_busy(tx_busy_s[2]),
    .wr_uart(wr_s[2]), .w_data(wd_s[2]), .busy(busy_s[2]), .dataSent(ds_s[2]), .err(err_s[2]));

  // UART model: busy from the cycle after a strobe, for hold_len cycles.
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        tx_busy_s[i] <= 1'b0;
        bcnt[i]      <= 0;
      end else if (wr_s[i]) begin
        tx_busy_s[i] <= 1'b1;
        bcnt[i]      <= hold_len[i] - 1;
      end else if (bcnt[i] > 0) begin
        bcnt[i] <= bcnt[i] - 1;
      end else begin
        tx_busy_s[i] <= 1'b0;
      end
    end
  end

  function automatic string fmt(input logic [7:0] q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  // Reference: view the masked bus as a list of bytes, order it, cut the window.
  task automatic model_frame(input int inst, input logic [23:0] d, input int ws, input int wl,
                             output logic [7:0] exp[$], output bit rej);
    logic [31:0] md;
    logic [7:0]  ordered[$];
    logic [7:0]  x;
    int          nb;
    int          len;
    nb  = nb_of[inst];
    md  = 32'(d) & ((32'h1 << bw_of[inst]) - 32'h1);
    exp.delete();
    rej = (ws >= nb);
    if (!rej) begin
      for (int k = 0; k < nb; k++) begin
        if (msb_of[inst] != 0) ordered.push_front(8'((md >> (8 * k)) & 32'hFF));
        else                   ordered.push_back(8'((md >> (8 * k)) & 32'hFF));
      end
      len = nb - ws;
      if (wl != 0 && wl < len) len = wl;
      if (hdr_of[inst] != 0) begin
        exp.push_back(8'hA5);
        exp.push_back(8'(len >> 8));
        exp.push_back(8'(len & 255));
      end
      for (int j = 0; j < len; j++) exp.push_back(ordered[ws + j]);
`ifdef DBG_STREAM_CHECKSUM_EN
      x = 8'h00;
      foreach (exp[i]) x = x ^ exp[i];
      exp.push_back(x);
`else
      x = 8'h00;
`endif
    end
  endtask

  task automatic run_frame(input int inst, input logic [23:0] d, input int ws, input int wl,
                           output logic [7:0] got[$], output int nds, output int nerr,
                           output int nviol, output int anybusy, output bit tmo);
    int tail;
    got.delete();
    nds = 0; nerr = 0; nviol = 0; anybusy = 0; tmo = 1'b1; tail = -1;
    @(posedge clock); #1;
    send_s[inst] = 1'b1; din_s[inst] = d; ws_s[inst] = 16'(ws); wl_s[inst] = 16'(wl);
    @(posedge clock); #1;
    // Scramble inputs after capture; the stream must come from the snapshot.
    send_s[inst] = 1'b0; din_s[inst] = 24'($urandom);
    ws_s[inst] = 16'($urandom); wl_s[inst] = 16'($urandom);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (wr_s[inst]) begin
        got.push_back(wd_s[inst]);
        if (tx_busy_s[inst]) nviol++;
      end
      if (ds_s[inst]) nds++;
      if (err_s[inst]) nerr++;
      if (busy_s[inst]) anybusy = 1;
      if (tail > 0) tail--;
      else if (tail == 0) begin
        tmo = 1'b0;
        break;
      end
      if (tail < 0 && (nds > 0 || nerr > 0)) tail = 4;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({wr_s[i], wd_s[i], busy_s[i], ds_s[i], err_s[i]} !== 12'h000) begin
        bad++;
        $display("FAIL reset_outputs inst%0d: got wr=%b wd=%02h busy=%b ds=%b err=%b, expected all 0",
                 i, wr_s[i], wd_s[i], busy_s[i], ds_s[i], err_s[i]);
      end
    end
  endtask

  task automatic test_full_window();
    logic [7:0] got[$], exp[$], x;
    int nds, nerr, nviol, anyb;
    bit tmo;
    hold_len[0] = 10;
    exp = '{8'hA5, 8'h00, 8'h03, 8'h12, 8'h34, 8'h56};
`ifdef DBG_STREAM_CHECKSUM_EN
    x = 8'h00;
    foreach (exp[i]) x = x ^ exp[i];
    exp.push_back(x);
`else
    x = 8'h00;
`endif
    run_frame(0, 24'h123456, 0, 0, got, nds, nerr, nviol, anyb, tmo);
    total++;
    if (tmo !== 1'b0) begin bad++; $display("FAIL full_window_timeout: got timeout=%0d expected 0", tmo); end
    total++;
    if (fmt(got) != fmt(exp)) begin bad++; $display("FAIL full_window_bytes: got %s expected %s", fmt(got), fmt(exp)); end
    total++;
    if (nds !== 1) begin bad++; $display("FAIL full_window_dataSent: got %0d pulses expected 1", nds); end
    total++;
    if (nviol !== 0 || nerr !== 0) begin
      bad++; $display("FAIL full_window_handshake: got strobes_while_busy=%0d err=%0d expected 0/0", nviol, nerr);
    end
  endtask

  task automatic test_truncate();
    logic [7:0] got[$], exp[$], x;
    int nds, nerr, nviol, anyb;
    bit tmo;
    hold_len[1] = 10;
    exp = '{8'hA5, 8'h00, 8'h02, 8'h34, 8'h12};
`ifdef DBG_STREAM_CHECKSUM_EN
    x = 8'h00;
    foreach (exp[i]) x = x ^ exp[i];
    exp.push_back(x);
`else
    x = 8'h00;
`endif
    run_frame(1, 24'h123456, 1, 5, got, nds, nerr, nviol, anyb, tmo);
    total++;
    if (fmt(got) != fmt(exp)) begin bad++; $display("FAIL truncate_bytes: got %s expected %s", fmt(got), fmt(exp)); end
    total++;
    if (nds !== 1 || nerr !== 0) begin bad++; $display("FAIL truncate_pulses: got ds=%0d err=%0d expected 1/0", nds, nerr); end
  endtask

  task automatic test_reject();
    logic [7:0] got[$];
    int nds, nerr, nviol, anyb;
    bit tmo;
    run_frame(0, 24'h123456, 3, 0, got, nds, nerr, nviol, anyb, tmo);
    total++;
    if (nerr !== 1) begin bad++; $display("FAIL reject_err: got %0d pulses expected 1", nerr); end
    total++;
    if (got.size() !== 0 || nds !== 0) begin
      bad++; $display("FAIL reject_no_tx: got strobes=%0d ds=%0d expected 0/0", got.size(), nds);
    end
    total++;
    if (anyb !== 0) begin bad++; $display("FAIL reject_busy: got busy seen=%0d expected 0", anyb); end
  endtask

  task automatic test_padding();
    logic [7:0] got[$], exp[$], x;
    int nds, nerr, nviol, anyb;
    bit tmo;
    hold_len[2] = 10;
    exp = '{8'h0A, 8'hBC, 8'hDE};
`ifdef DBG_STREAM_CHECKSUM_EN
    x = 8'h00;
    foreach (exp[i]) x = x ^ exp[i];
    exp.push_back(x);
`else
    x = 8'h00;
`endif
    run_frame(2, 24'h0ABCDE, 0, 0, got, nds, nerr, nviol, anyb, tmo);
    total++;
    if (fmt(got) != fmt(exp)) begin bad++; $display("FAIL padding_bytes: got %s expected %s", fmt(got), fmt(exp)); end
    total++;
    if (nds !== 1) begin bad++; $display("FAIL padding_dataSent: got %0d pulses expected 1", nds); end
  endtask

  task automatic test_abort_reset();
    logic [7:0] got[$], exp[$], x;
    int nds, nerr, nviol, anyb, n, late;
    bit tmo, seen;
    hold_len[0] = 10;
    n = 0; seen = 1'b0; late = 0;
    @(posedge clock); #1;
    send_s[0] = 1'b1; din_s[0] = 24'h123456; ws_s[0] = 16'd0; wl_s[0] = 16'd0;
    @(posedge clock); #1;
    send_s[0] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (wr_s[0]) n++;
      if (n == 5) begin seen = 1'b1; break; end
    end
    total++;
    if (seen !== 1'b1) begin bad++; $display("FAIL abort_reach_byte: got %0d strobes expected 5", n); end
    // New request while the second data byte is in flight.
    @(posedge clock); #1;
    send_s[0] = 1'b1; din_s[0] = 24'hFEDCBA;
    @(posedge clock); #1;
    send_s[0] = 1'b0;
    @(negedge clock);
    total++;
    if ({err_s[0], busy_s[0]} !== 2'b01) begin
      bad++; $display("FAIL abort_send_ignored: got err=%b busy=%b expected 0/1", err_s[0], busy_s[0]);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({wr_s[0], wd_s[0], busy_s[0], ds_s[0], err_s[0]} !== 12'h000) begin
      bad++; $display("FAIL abort_async_clear: got wr=%b wd=%02h busy=%b ds=%b err=%b expected all 0",
                      wr_s[0], wd_s[0], busy_s[0], ds_s[0], err_s[0]);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (ds_s[0] || wr_s[0] || busy_s[0]) late++;
    end
    total++;
    if (late !== 0) begin bad++; $display("FAIL abort_quiet: got %0d active cycles expected 0", late); end
    exp = '{8'hA5, 8'h00, 8'h03, 8'h65, 8'h43, 8'h21};
`ifdef DBG_STREAM_CHECKSUM_EN
    x = 8'h00;
    foreach (exp[i]) x = x ^ exp[i];
    exp.push_back(x);
`else
    x = 8'h00;
`endif
    run_frame(0, 24'h654321, 0, 0, got, nds, nerr, nviol, anyb, tmo);
    total++;
    if (fmt(got) != fmt(exp) || nds !== 1) begin
      bad++; $display("FAIL abort_restart: got %s ds=%0d expected %s ds=1", fmt(got), nds, fmt(exp));
    end
  endtask

  task automatic test_random();
    logic [7:0] got[$], exp[$];
    logic [23:0] d;
    int nds, nerr, nviol, anyb, inst, ws, wl;
    bit tmo, rej;
    for (int it = 0; it < 30; it++) begin
      inst = $urandom_range(0, 2);
      d    = 24'($urandom);
      ws   = $urandom_range(0, 3);
      wl   = $urandom_range(0, 5);
      hold_len[inst] = $urandom_range(1, 4);
      model_frame(inst, d, ws, wl, exp, rej);
      run_frame(inst, d, ws, wl, got, nds, nerr, nviol, anyb, tmo);
      total++;
      if (fmt(got) != fmt(exp)) begin
        bad++; $display("FAIL random_bytes it%0d inst%0d ws=%0d wl=%0d: got %s expected %s",
                        it, inst, ws, wl, fmt(got), fmt(exp));
      end
      total++;
      if (nds !== (rej ? 0 : 1) || nerr !== (rej ? 1 : 0)) begin
        bad++; $display("FAIL random_pulses it%0d: got ds=%0d err=%0d expected %0d/%0d",
                        it, nds, nerr, rej ? 0 : 1, rej ? 1 : 0);
      end
      total++;
      if (nviol !== 0 || tmo !== 1'b0) begin
        bad++; $display("FAIL random_handshake it%0d: got strobes_while_busy=%0d timeout=%0d expected 0/0",
                        it, nviol, tmo);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_s[i] = 1'b0; din_s[i] = '0; ws_s[i] = '0; wl_s[i] = '0; hold_len[i] = 10;
    end
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b1;
    test_full_window();
    test_truncate();
    test_reject();
    test_padding();
    test_abort_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
